ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard over the shared PS/2 clock/data lines, the opposite direction of the existing `keyboardController` receive path. It sits beside `keyboardController`, drives the open-drain lines through active-high pull-low enables, and raises `busy` so the receiver ignores line activity it causes.

---
 rtl/ps2_host_tx.sv | 216 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, then shifts one command byte
// out on device-generated clock edges and reports the device's ack or a timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [IW-1:0] INH_ONE  = IW'(1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_ONE   = TW'(1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [FW-1:0] FLT_ONE  = FW'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_START     = 3'd2,
        S_SEND      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    state_t          state_r;
    logic [1:0]      clk_sync_r;
    logic [1:0]      dat_sync_r;
    logic            clk_filt_r;
    logic [FW-1:0]   flt_cnt_r;
    logic            fall_r;
    logic [7:0]      data_r;
    logic            par_r;
    logic [3:0]      bit_cnt_r;
    logic [IW-1:0]   inh_cnt_r;
    logic [TW-1:0]   to_cnt_r;
    logic            err_r;
    logic [TW-1:0]   to_next_s;
    logic            to_hit_s;
    logic [3:0]      bit_next_s;

    // Two-flop synchronizers for both raw lines; idle level is high.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_sync_r <= 2'b11;
            dat_sync_r <= 2'b11;
        end else begin
            clk_sync_r <= {clk_sync_r[0], ps2_clk_in};
            dat_sync_r <= {dat_sync_r[0], ps2_dat_in};
        end
    end

    // Clock agreement filter; fall_r strobes in the cycle the filtered level drops.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_filt_r <= 1'b1;
            flt_cnt_r  <= {FW{1'b0}};
            fall_r     <= 1'b0;
        end else begin
            fall_r <= 1'b0;
            if (clk_sync_r[1] != clk_filt_r) begin
                if (flt_cnt_r == FLT_LAST) begin
                    clk_filt_r <= clk_sync_r[1];
                    flt_cnt_r  <= {FW{1'b0}};
                    fall_r     <= clk_filt_r;
                end else begin
                    flt_cnt_r <= flt_cnt_r + FLT_ONE;
                end
            end else begin
                flt_cnt_r <= {FW{1'b0}};
            end
        end
    end

    // Saturating timeout increment and next bit index.
    always_comb begin
        to_next_s  = (to_cnt_r == TO_LIMIT) ? to_cnt_r : (to_cnt_r + TO_ONE);
        to_hit_s   = (to_next_s == TO_LIMIT);
        bit_next_s = bit_cnt_r + 4'd1;
    end

    // Transaction FSM with registered line enables and status outputs.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            data_r     <= 8'h00;
            par_r      <= 1'b0;
            bit_cnt_r  <= 4'd0;
            inh_cnt_r  <= {IW{1'b0}};
            to_cnt_r   <= {TW{1'b0}};
            err_r      <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            busy       <= 1'b0;
            tx_ready   <= 1'b1;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        data_r     <= tx_data;
                        par_r      <= odd_parity(tx_data);
                        inh_cnt_r  <= {IW{1'b0}};
                        ps2_clk_oe <= 1'b1;
                        busy       <= 1'b1;
                        tx_ready   <= 1'b0;
                        state_r    <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (inh_cnt_r == INH_LAST) begin
                        ps2_dat_oe <= 1'b1;
                        state_r    <= S_START;
                    end else begin
                        inh_cnt_r <= inh_cnt_r + INH_ONE;
                    end
                end
                S_START: begin
                    ps2_clk_oe <= 1'b0;
                    bit_cnt_r  <= 4'd0;
                    to_cnt_r   <= {TW{1'b0}};
                    err_r      <= 1'b0;
                    state_r    <= S_SEND;
                end
                S_SEND: begin
                    to_cnt_r <= to_next_s;
                    if (to_hit_s) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_done    <= 1'b1;
                        tx_error   <= 1'b1;
                        busy       <= 1'b0;
                        tx_ready   <= 1'b1;
                        state_r    <= S_IDLE;
                    end else if (fall_r) begin
                        bit_cnt_r <= bit_next_s;
                        case (bit_next_s)
                            4'd1, 4'd2, 4'd3, 4'd4,
                            4'd5, 4'd6, 4'd7, 4'd8: ps2_dat_oe <= ~data_r[bit_cnt_r[2:0]];
                            4'd9:                   ps2_dat_oe <= ~par_r;
                            default: begin
                                // Stop bit: release data and wait for the device ack edge.
                                ps2_dat_oe <= 1'b0;
                                state_r    <= S_ACK;
                            end
                        endcase
                    end
                end
                S_ACK: begin
                    to_cnt_r <= to_next_s;
                    if (to_hit_s) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_done    <= 1'b1;
                        tx_error   <= 1'b1;
                        busy       <= 1'b0;
                        tx_ready   <= 1'b1;
                        state_r    <= S_IDLE;
                    end else if (fall_r) begin
                        bit_cnt_r <= bit_next_s;
                        err_r     <= dat_sync_r[1];
                        state_r   <= S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    to_cnt_r <= to_next_s;
                    if (to_hit_s) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_done    <= 1'b1;
                        tx_error   <= 1'b1;
                        busy       <= 1'b0;
                        tx_ready   <= 1'b1;
                        state_r    <= S_IDLE;
                    end else if (clk_filt_r && dat_sync_r[1]) begin
                        tx_done  <= 1'b1;
                        tx_error <= err_r;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                        state_r  <= S_IDLE;
                    end
                end
                default: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    busy       <= 1'b0;
                    tx_ready   <= 1'b1;
                    state_r    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus with a behavioural keyboard that clocks
// frames, decodes the bits it sees and optionally acks, plus timing checks.
module tb_ps2_host_tx;

    localparam int INH  = 60;
    localparam int TO   = 2000;
    localparam int FL   = 8;
    localparam int HALF = 40;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_error;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       ps2_clk_in, ps2_dat_in;
    logic       dev_clk  = 1'b1;
    logic       dev_dat  = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    assign ps2_clk_in = ~ps2_clk_oe & dev_clk;
    assign ps2_dat_in = ~ps2_dat_oe & dev_dat;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN    (FL)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .tx_done   (tx_done),
        .tx_error  (tx_error),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        if (tx_done) done_cnt <= done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Accept a byte and check the inhibit / start-bit / release timeline exactly.
    task automatic send_start(input logic [7:0] d);
        check_eq("ready_before", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        check_eq("clk_oe_accept", ps2_clk_oe, 1);
        check_eq("busy_accept", busy, 1);
        check_eq("ready_accept", tx_ready, 0);
        tick(INH - 1);
        check_eq("dat_oe_early", ps2_dat_oe, 0);
        check_eq("inhibit_hold", ps2_clk_oe, 1);
        tick(1);
        check_eq("start_dat_oe", ps2_dat_oe, 1);
        check_eq("start_clk_oe", ps2_clk_oe, 1);
        tick(1);
        check_eq("clk_release", ps2_clk_oe, 0);
        check_eq("start_held", ps2_dat_oe, 1);
    endtask

    // Keyboard model: mode 0 plain, 1 = stray tx_valid mid-frame, 2 = reset during bit 4.
    task automatic device_frame(input logic [7:0] d, input bit ack, input int mode,
                                output bit aborted);
        logic [10:0] exp_bits;
        exp_bits = {1'b1, ($countones(d) % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
        aborted  = 1'b0;
        check_eq("start_line", ps2_dat_in, exp_bits[0]);
        tick(HALF);
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            if (mode == 1 && k == 4) begin
                tick(2);
                tx_data  = 8'hFF;
                tx_valid = 1'b1;
                tick(1);
                check_eq("ready_in_send", tx_ready, 0);
                tx_valid = 1'b0;
                tick(HALF - 3);
            end else if (mode == 2 && k == 4) begin
                tick(HALF / 2);
                reset = 1'b1;
                #1;
                check_eq("rst_clk_oe", ps2_clk_oe, 0);
                check_eq("rst_dat_oe", ps2_dat_oe, 0);
                check_eq("rst_no_done", tx_done, 0);
                dev_clk = 1'b1;
                tick(3);
                reset   = 1'b0;
                aborted = 1'b1;
                return;
            end else begin
                tick(HALF);
            end
            check_eq($sformatf("bit%0d_%02h", k, d), ps2_dat_in, exp_bits[k]);
            dev_clk = 1'b1;
            tick(HALF);
        end
        if (ack) dev_dat = 1'b0;
        tick(HALF);
        dev_clk = 1'b0;
        tick(HALF);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
    endtask

    task automatic wait_done(input bit exp_err);
        int i = 0;
        while (tx_done !== 1'b1 && i < 600) begin
            tick(1);
            i++;
        end
        check_eq("done_seen", tx_done, 1);
        check_eq("tx_error", tx_error, exp_err);
        check_eq("done_clk_oe", ps2_clk_oe, 0);
        check_eq("done_dat_oe", ps2_dat_oe, 0);
        tick(1);
        check_eq("done_width", tx_done, 0);
        check_eq("ready_after", tx_ready, 1);
        check_eq("busy_after", busy, 0);
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack, input int mode);
        bit aborted;
        send_start(d);
        device_frame(d, ack, mode, aborted);
        if (!aborted) wait_done(!ack);
    endtask

    initial begin
        int c;
        tick(3);
        check_eq("rst_ready", tx_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", tx_done, 0);
        check_eq("rst_error", tx_error, 0);
        check_eq("rst_clk_oe0", ps2_clk_oe, 0);
        check_eq("rst_dat_oe0", ps2_dat_oe, 0);
        reset = 1'b0;
        tick(2);

        run_frame(8'hED, 1'b1, 0);
        run_frame(8'h01, 1'b1, 0);
        run_frame(8'h00, 1'b1, 0);
        // Back-to-back: 0xED with a stray request in flight, then 0x02 immediately.
        run_frame(8'hED, 1'b1, 1);
        run_frame(8'h02, 1'b1, 0);

        for (int r = 0; r < 4; r++) begin
            run_frame(8'($urandom), 1'($urandom_range(0, 1)), 0);
        end

        run_frame(8'hF4, 1'b0, 0);

        // Device never clocks after release.
        send_start(8'hFF);
        tick(TO - 1);
        check_eq("to_not_yet", tx_done, 0);
        tick(1);
        check_eq("to_done", tx_done, 1);
        check_eq("to_error", tx_error, 1);
        check_eq("to_clk_oe", ps2_clk_oe, 0);
        check_eq("to_dat_oe", ps2_dat_oe, 0);
        tick(1);
        check_eq("to_ready", tx_ready, 1);

        c = done_cnt;
        run_frame(8'hED, 1'b1, 2);
        tick(200);
        check_eq("rst_done_cnt", done_cnt, c);
        check_eq("rst_ready_after", tx_ready, 1);
        run_frame(8'hF4, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
